// File: rtl/crossy_game_ctrl_if.sv
// Signal bundle between the crossy-road game controller and its surroundings
// (buttons, renderer collision flag, VGA frame tick, and the game state it publishes).
interface crossy_game_ctrl_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic       collision;
  logic [1:0] game_state;
  logic [3:0] player_x;
  logic [1:0] player_lane;
  logic [7:0] score;
  logic [2:0] speed_level;
  logic       scroll_pulse;
  logic       death_flash;

  modport master (
    output frame_tick, btn_up, btn_left, btn_right, btn_start, collision,
    input  game_state, player_x, player_lane, score, speed_level, scroll_pulse, death_flash
  );

  modport slave (
    input  frame_tick, btn_up, btn_left, btn_right, btn_start, collision,
    output game_state, player_x, player_lane, score, speed_level, scroll_pulse, death_flash
  );
endinterface

// File: rtl/crossy_game_ctrl.sv
// Crossy-road game sequencer: conditions buttons into frame-aligned moves and
// runs the IDLE/PLAY/DYING/OVER flow, owning position, score and scroll requests.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | after reset, waiting for a start press
//   ST_PLAY  | one queued move applied per frame tick, collision ends run
//   ST_DYING | death animation, counts frame ticks, flash on odd counts
//   ST_OVER  | final position/score held, start press begins a new run
module crossy_game_ctrl #(
  parameter int COLS         = 16,
  parameter int SCROLL_ROW   = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int SPEED_SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  crossy_game_ctrl_if.slave gif
);

  localparam int         CNT_W    = $clog2(DEATH_FRAMES);
  localparam logic [3:0] X_MID    = 4'(COLS / 2);
  localparam logic [3:0] X_MAX    = 4'(COLS - 1);
  localparam logic [1:0] LANE_TOP = 2'(SCROLL_ROW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       sync1, sync2, sync3;
  logic [3:0]       edges;
  logic [2:0]       pend, pend_nx;
  logic [3:0]       x, x_nx;
  logic [1:0]       lane, lane_nx;
  logic [7:0]       score, score_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             scroll, scroll_nx;
  logic             flash, flash_nx;
  logic [7:0]       speed_raw;

  // Bit order throughout: {start, right, left, up}
  assign edges = sync2 & ~sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      state  <= ST_IDLE;
      pend   <= '0;
      x      <= X_MID;
      lane   <= '0;
      score  <= '0;
      cnt    <= '0;
      scroll <= 1'b0;
      flash  <= 1'b0;
    end else begin
      sync1  <= {gif.btn_start, gif.btn_right, gif.btn_left, gif.btn_up};
      sync2  <= sync1;
      sync3  <= sync2;
      state  <= state_nx;
      pend   <= pend_nx;
      x      <= x_nx;
      lane   <= lane_nx;
      score  <= score_nx;
      cnt    <= cnt_nx;
      scroll <= scroll_nx;
      flash  <= flash_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    x_nx      = x;
    lane_nx   = lane;
    score_nx  = score;
    cnt_nx    = cnt;
    scroll_nx = 1'b0;
    // An edge coincident with frame_tick survives the clear and counts next frame
    pend_nx   = (gif.frame_tick ? 3'b000 : pend) | edges[2:0];

    case (state)
      ST_IDLE, ST_OVER: begin
        if (edges[3]) begin
          state_nx = ST_PLAY;
          x_nx     = X_MID;
          lane_nx  = '0;
          score_nx = '0;
          pend_nx  = '0;
        end
      end
      ST_PLAY: begin
        if (gif.frame_tick) begin
          if (gif.collision) begin
            state_nx = ST_DYING;
            cnt_nx   = '0;
          end else if (pend[0]) begin
            if (score != 8'hff) score_nx = score + 8'd1;
            if (lane < LANE_TOP) lane_nx = lane + 2'd1;
            else                 scroll_nx = 1'b1;
          end else if (pend[1]) begin
            if (x != 4'd0) x_nx = x - 4'd1;
          end else if (pend[2]) begin
            if (x != X_MAX) x_nx = x + 4'd1;
          end
        end
      end
      ST_DYING: begin
        if (gif.frame_tick) begin
          if (cnt == CNT_LAST) state_nx = ST_OVER;
          else                 cnt_nx   = cnt + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    flash_nx = (state_nx == ST_DYING) && cnt_nx[0];
  end

  assign speed_raw = score >> SPEED_SHIFT;

  assign gif.game_state   = state;
  assign gif.player_x     = x;
  assign gif.player_lane  = lane;
  assign gif.score        = score;
  assign gif.speed_level  = (speed_raw > 8'd7) ? 3'd7 : speed_raw[2:0];
  assign gif.scroll_pulse = scroll;
  assign gif.death_flash  = flash;

endmodule

// File: tb/tb_crossy_game_ctrl.sv
// Bench for crossy_game_ctrl: directed scenarios plus random button/frame/collision
// traffic, every cycle compared against a rule-level game model.
module tb_crossy_game_ctrl;
  localparam int COLS         = 16;
  localparam int SCROLL_ROW   = 3;
  localparam int DEATH_FRAMES = 60;
  localparam int SPEED_SHIFT  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn  = 4'b0000;   // {start, right, left, up}
  logic       ft   = 1'b0;
  logic       coll = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int sc_cnt   = 0;

  crossy_game_ctrl_if gif();

  assign gif.btn_up     = btn[0];
  assign gif.btn_left   = btn[1];
  assign gif.btn_right  = btn[2];
  assign gif.btn_start  = btn[3];
  assign gif.frame_tick = ft;
  assign gif.collision  = coll;

  crossy_game_ctrl #(
    .COLS(COLS), .SCROLL_ROW(SCROLL_ROW),
    .DEATH_FRAMES(DEATH_FRAMES), .SPEED_SHIFT(SPEED_SHIFT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .gif  (gif.slave)
  );

  always #5 clk = ~clk;

  // Game model: 0=idle 1=play 2=dying 3=over; presses reach the game 3 clocks late
  int       m_state, m_x, m_lane, m_score, m_ticks, m_scroll, m_flash;
  bit [2:0] m_pend;
  bit [3:0] h1, h2, h3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_x = COLS / 2; m_lane = 0; m_score = 0;
    m_ticks = 0; m_scroll = 0; m_flash = 0; m_pend = '0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic model_step();
    bit [3:0] e;
    bit entered;
    e = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = btn;
    entered  = 1'b0;
    m_scroll = 0;
    if ((m_state == 0 || m_state == 3) && e[3]) begin
      m_state = 1; m_x = COLS / 2; m_lane = 0; m_score = 0;
      entered = 1'b1;
    end else if (m_state == 1 && ft) begin
      if (coll) begin
        m_state = 2; m_ticks = 0;
      end else if (m_pend[0]) begin
        m_score = (m_score < 255) ? m_score + 1 : 255;
        if (m_lane < SCROLL_ROW) m_lane++;
        else m_scroll = 1;
      end else if (m_pend[1]) begin
        m_x = (m_x > 0) ? m_x - 1 : 0;
      end else if (m_pend[2]) begin
        m_x = (m_x < COLS - 1) ? m_x + 1 : COLS - 1;
      end
    end else if (m_state == 2 && ft) begin
      m_ticks++;
      if (m_ticks == DEATH_FRAMES) m_state = 3;
    end
    if (entered) m_pend = '0;
    else         m_pend = (ft ? 3'b000 : m_pend) | e[2:0];
    m_flash = (m_state == 2 && (m_ticks % 2) == 1) ? 1 : 0;
  endtask

  task automatic check_all();
    int spd;
    spd = m_score / (1 << SPEED_SHIFT);
    if (spd > 7) spd = 7;
    chk("game_state",   gif.game_state,   m_state);
    chk("player_x",     gif.player_x,     m_x);
    chk("player_lane",  gif.player_lane,  m_lane);
    chk("score",        gif.score,        m_score);
    chk("speed_level",  gif.speed_level,  spd);
    chk("scroll_pulse", gif.scroll_pulse, m_scroll);
    chk("death_flash",  gif.death_flash,  m_flash);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (gif.scroll_pulse === 1'b1) sc_cnt++;
    check_all();
  endtask

  task automatic frame(input logic c);
    ft = 1'b1; coll = c;
    cycle();
    ft = 1'b0; coll = 1'b0;
  endtask

  task automatic press(input logic [3:0] mask);
    btn = btn | mask;
    repeat (4) cycle();
    btn = btn & ~mask;
    repeat (4) cycle();
  endtask

  // Called just after a negedge so reset lands mid-cycle
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_state", gif.game_state, 0);
    chk("rst_x", gif.player_x, COLS / 2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ft_cd;
    model_reset();
    #12;
    check_all();
    chk("reset_x", gif.player_x, 8);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Start from IDLE
    press(4'b1000);
    chk("start_state", gif.game_state, 1);
    chk("start_x", gif.player_x, 8);
    chk("start_lane", gif.player_lane, 0);

    // Four ups: lanes 1,2,3 then a scroll
    sc_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      press(4'b0001);
      frame(1'b0);
      chk("up_lane", gif.player_lane, (i < 3) ? i : 3);
    end
    repeat (2) cycle();
    chk("scroll_cnt", sc_cnt, 1);
    chk("up_score", gif.score, 4);

    // Left and up in one frame: only up wins
    press(4'b0011);
    frame(1'b0);
    chk("prio_x", gif.player_x, 8);
    chk("prio_score", gif.score, 5);

    for (int i = 0; i < 10; i++) begin press(4'b0010); frame(1'b0); end
    chk("left_clamp", gif.player_x, 0);
    for (int i = 0; i < 16; i++) begin press(4'b0100); frame(1'b0); end
    chk("right_clamp", gif.player_x, 15);
    press(4'b0010); frame(1'b0);
    chk("x_14", gif.player_x, 14);

    // Collision with a pending right
    press(4'b0100);
    frame(1'b1);
    chk("die_state", gif.game_state, 2);
    chk("die_x", gif.player_x, 14);
    for (int k = 1; k <= DEATH_FRAMES; k++) begin
      repeat (3) cycle();
      frame(1'b0);
      if (k < DEATH_FRAMES) begin
        chk("dying_state", gif.game_state, 2);
        chk("dying_flash", gif.death_flash, k % 2);
      end
    end
    chk("over_state", gif.game_state, 3);
    chk("over_x", gif.player_x, 14);

    // Restart from OVER, then score saturation
    press(4'b1000);
    chk("restart_state", gif.game_state, 1);
    chk("restart_score", gif.score, 0);
    for (int i = 0; i < 40; i++) begin press(4'b0001); frame(1'b0); end
    chk("score_40", gif.score, 40);
    chk("speed_2", gif.speed_level, 2);
    for (int i = 0; i < 260; i++) begin press(4'b0001); frame(1'b0); end
    chk("score_sat", gif.score, 255);
    chk("speed_7", gif.speed_level, 7);

    // Reset while dying
    frame(1'b1);
    repeat (5) begin cycle(); frame(1'b0); end
    chk("pre_rst_state", gif.game_state, 2);
    async_reset();
    cycle();
    press(4'b1000);
    chk("post_rst_state", gif.game_state, 1);

    // Random traffic
    ft_cd = 5;
    for (int n = 0; n < 9000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      coll = ($urandom_range(0, 24) == 0);
      if (ft_cd == 0) begin
        ft = 1'b1;
        ft_cd = $urandom_range(2, 10);
      end else begin
        ft = 1'b0;
        ft_cd--;
      end
      cycle();
      if ($urandom_range(0, 2999) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
